// File: rtl/axis_frame_player.sv
// RAM-backed AXI-Stream sample source: replays a stored buffer as FFT_LEN-sample frames with tlast.
// Output register plus a one-entry skid buffer sustain 1 sample/clk under any tready pattern.
module axis_frame_player #(
  parameter int WIDTH   = 16,
  parameter int FFT_LEN = 64,
  parameter int FRAMES  = 20,
  parameter int SAMP    = FRAMES * FFT_LEN,
  parameter int CNT_WID = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(SAMP)-1:0]  wr_addr,
  input  logic [2*WIDTH-1:0]       wr_data,
  input  logic                     start,
  input  logic                     loop_en,
  input  logic                     abort,
  output logic [2*WIDTH-1:0]       m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WID-1:0]       frame_cnt
);

  localparam int AW = $clog2(SAMP);
  localparam int IW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mem [SAMP];
  logic [2*WIDTH-1:0] ram_q;
  logic [AW-1:0]      rd_addr;
  logic [IW-1:0]      rd_idx;
  logic               rd_pend, rd_last, rd_fin, rd_stop;
  logic [2*WIDTH-1:0] sk_data;
  logic               sk_valid, sk_last, sk_fin;
  logic               out_fin;
  logic               abort_q;

  logic       hs, end_now, issue, last_addr, last_idx;
  logic [1:0] occ_after;

  // A read is issued only if the word it returns will find a free slot even with tready held low.
  always_comb begin
    hs        = m_axis_tvalid && m_axis_tready;
    end_now   = (state == RUN) && hs && ((m_axis_tlast && (abort_q || abort)) || out_fin);
    occ_after = 2'(m_axis_tvalid) + 2'(sk_valid) + 2'(rd_pend) - 2'(hs);
    last_addr = (rd_addr == AW'(SAMP - 1));
    last_idx  = (rd_idx == IW'(FFT_LEN - 1));
    issue     = ((state == PRIME) || ((state == RUN) && !rd_stop && !end_now))
                && (occ_after <= 2'd1);
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy && (int'(wr_addr) < SAMP))
      mem[wr_addr] <= wr_data;
    if (issue)
      ram_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_cnt     <= '0;
      abort_q       <= 1'b0;
      rd_addr       <= '0;
      rd_idx        <= '0;
      rd_pend       <= 1'b0;
      rd_last       <= 1'b0;
      rd_fin        <= 1'b0;
      rd_stop       <= 1'b0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_last       <= 1'b0;
      sk_fin        <= 1'b0;
      out_fin       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (busy && abort)
        abort_q <= 1'b1;
      if (hs && m_axis_tlast)
        frame_cnt <= frame_cnt + 1'b1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= PRIME;
            busy      <= 1'b1;
            done      <= 1'b0;
            frame_cnt <= '0;
            abort_q   <= 1'b0;
            rd_addr   <= '0;
            rd_idx    <= '0;
            rd_stop   <= 1'b0;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          if (end_now) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // loop_en is decided here, when the last address is fetched.
      if (issue) begin
        rd_addr <= last_addr ? '0 : rd_addr + 1'b1;
        rd_idx  <= last_idx ? '0 : rd_idx + 1'b1;
        rd_last <= last_idx;
        rd_fin  <= last_addr && !loop_en;
        if (last_addr && !loop_en)
          rd_stop <= 1'b1;
      end
      rd_pend <= issue;

      if (end_now) begin
        m_axis_tvalid <= 1'b0;
        sk_valid      <= 1'b0;
      end else if (!m_axis_tvalid || hs) begin
        if (sk_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= sk_data;
          m_axis_tlast  <= sk_last;
          out_fin       <= sk_fin;
          sk_valid      <= rd_pend;
          sk_data       <= ram_q;
          sk_last       <= rd_last;
          sk_fin        <= rd_fin;
        end else if (rd_pend) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= ram_q;
          m_axis_tlast  <= rd_last;
          out_fin       <= rd_fin;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end else if (rd_pend) begin
        sk_valid <= 1'b1;
        sk_data  <= ram_q;
        sk_last  <= rd_last;
        sk_fin   <= rd_fin;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_player.sv
// Bench for axis_frame_player: table of playback scenarios plus randomized runs against a queue model.
module tb_axis_frame_player;
  localparam int WIDTH = 16, FFT_LEN = 8, FRAMES = 2, SAMP = 16, CNT_WID = 16;
  localparam int AW = 4, DW = 32;

  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, loop_en = 1'b0, abort = 1'b0;
  logic tready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] tdata;
  logic tvalid, tlast, busy, done;
  logic [CNT_WID-1:0] frame_cnt;

  axis_frame_player #(.WIDTH(WIDTH), .FFT_LEN(FFT_LEN), .FRAMES(FRAMES), .SAMP(SAMP),
                      .CNT_WID(CNT_WID)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .loop_en(loop_en), .abort(abort),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .done(done), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit lp; int pct; int abort_hs; int poke_hs; bit st_abort; int exp_total; int exp_frames;
  } vec_t;

  int n_tests = 0, n_fail = 0, nacc = 0;
  logic [DW-1:0] ram_m [SAMP];
  logic [DW:0]   exp_q [$];
  vec_t          tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic logic rdy(input int pct);
    return $urandom_range(1, 100) <= pct;
  endfunction

  function automatic int model_total(input bit lp, input int ab);
    int t;
    if (ab < 0) return SAMP;
    t = (ab / FFT_LEN + 1) * FFT_LEN;
    if (!lp && t > SAMP) t = SAMP;
    return t;
  endfunction

  // One clock: checks any handshake against the model queue and stability under backpressure.
  task automatic cyc();
    logic pv, pr, pl, prst;
    logic [DW-1:0] pd;
    logic [DW:0] e;
    pv = tvalid; pr = tready; pd = tdata; pl = tlast; prst = rst_n;
    @(posedge clk); #1;
    if (prst && pv === 1'b1 && pr) begin
      if (exp_q.size() == 0) fail("extra_beat", nacc, 0);
      else begin
        e = exp_q.pop_front();
        chk("tdata", 64'(pd), 64'(e[DW-1:0]));
        chk("tlast", 64'(pl), 64'(e[DW]));
        nacc++;
        chk("frame_cnt", 64'(frame_cnt), 64'(CNT_WID'(nacc / FFT_LEN)));
      end
    end else if (prst && pv === 1'b1 && !pr) begin
      chk("hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, pl, pd}));
    end
  endtask

  task automatic fill_exp(input int total);
    exp_q.delete();
    nacc = 0;
    for (int i = 0; i < total; i++)
      exp_q.push_back({((i % FFT_LEN) == FFT_LEN - 1) ? 1'b1 : 1'b0, ram_m[i % SAMP]});
  endtask

  task automatic run_scn(input vec_t v);
    int budget;
    bit ab_sent, pk_sent;
    ab_sent = 0; pk_sent = 0;
    fill_exp(v.exp_total);
    loop_en = v.lp;
    start = 1'b1; abort = v.st_abort; tready = rdy(v.pct);
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("busy_start", 64'(busy), 64'd1);
    chk("done_clr", 64'(done), 64'd0);
    chk("lat1", 64'(tvalid), 64'd0);
    tready = rdy(v.pct); cyc();
    chk("lat2", 64'(tvalid), 64'd0);
    tready = rdy(v.pct); cyc();
    chk("lat3", 64'({tvalid, tdata}), 64'({1'b1, ram_m[0]}));
    budget = 0;
    while (!done && budget < 2000) begin
      tready = rdy(v.pct); abort = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (v.abort_hs >= 0 && !ab_sent && nacc == v.abort_hs) begin abort = 1'b1; ab_sent = 1; end
      if (v.poke_hs >= 0 && !pk_sent && nacc == v.poke_hs) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEAD; start = 1'b1; pk_sent = 1;
      end
      if (v.pct == 100) chk("no_gap", 64'(tvalid), 64'd1);
      cyc();
      budget++;
    end
    abort = 1'b0; wr_en = 1'b0; start = 1'b0;
    if (budget >= 2000) fail("done_timeout", budget, 2000);
    chk("total", 64'(nacc), 64'(v.exp_total));
    chk("frames", 64'(frame_cnt), 64'(v.exp_frames));
    chk("end_state", 64'({busy, done, tvalid}), 64'(3'b010));
    chk("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load_ram(input bit rnd);
    for (int i = 0; i < SAMP; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = rnd ? $urandom : DW'(i);
      ram_m[i] = wr_data;
      cyc();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int b;
    vec_t rv;
    tbl[0] = '{1'b0, 100, -1, -1, 1'b0, 16, 2};
    tbl[1] = '{1'b0,  50, -1, -1, 1'b0, 16, 2};
    tbl[2] = '{1'b1, 100, 40, -1, 1'b0, 48, 6};
    tbl[3] = '{1'b1, 100, 11, -1, 1'b0, 16, 2};
    tbl[4] = '{1'b1, 100,  7, -1, 1'b0,  8, 1};
    tbl[5] = '{1'b1,  50, 20, -1, 1'b0, 24, 3};
    tbl[6] = '{1'b0,  70,  3, -1, 1'b0,  8, 1};
    tbl[7] = '{1'b0, 100, -1,  3, 1'b1, 16, 2};
    tbl[8] = '{1'b0, 100, -1, -1, 1'b0, 16, 2};

    cyc(); cyc();
    chk("rst_ctl", 64'({tvalid, tlast, busy, done}), 64'd0);
    chk("rst_data", 64'(tdata), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    rst_n = 1'b1;
    load_ram(1'b0);

    for (int i = 0; i < 9; i++) run_scn(tbl[i]);

    // idle write lands and is replayed first
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEAD; cyc(); wr_en = 1'b0;
    ram_m[0] = 32'hDEAD;
    run_scn(tbl[0]);

    // reset in the middle of a frame
    fill_exp(SAMP);
    loop_en = 1'b0; tready = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    b = 0;
    while (nacc < 5 && b < 50) begin cyc(); b++; end
    if (b >= 50) fail("pre_rst_timeout", nacc, 5);
    chk("pre_rst_data", 64'(tdata), 64'(ram_m[5]));
    tready = 1'b0; rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("mid_rst_ctl", 64'({tvalid, tlast, busy, done}), 64'd0);
    chk("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    chk("mid_rst_data", 64'(tdata), 64'd0);
    exp_q.delete();
    tready = 1'b1; cyc();
    chk("post_rst_idle", 64'(tvalid), 64'd0);
    run_scn(tbl[0]);

    for (int k = 0; k < 6; k++) begin
      load_ram(1'b1);
      rv.lp = 1'($urandom_range(0, 1));
      rv.pct = int'($urandom_range(30, 100));
      if (rv.lp) rv.abort_hs = int'($urandom_range(0, 50));
      else rv.abort_hs = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      rv.poke_hs = -1;
      rv.st_abort = 1'($urandom_range(0, 1));
      rv.exp_total = model_total(rv.lp, rv.abort_hs);
      rv.exp_frames = rv.exp_total / FFT_LEN;
      run_scn(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
